terrain_grid_multi: RTL and testbench
=====================================

# terrain_grid_multi

Parametrised terrain store for the Digger playfield. It keeps a cell-granular solid/dug map of the board, clears cells where the player digs, and draws the remaining terrain into the pixel pipeline. Once per frame it answers neighbourhood queries for N_ALIEN aliens (free directions) and N_GOLD gold bags (can fall). It replaces the single-alien/single-gold terrain block and sits beside the other object drawers feeding the priority mux.

## Interface
- BOARD_X, 11'd32, board top-left X (pixels)
- BOARD_Y, 11'd160, board top-left Y (pixels)
- COLS, 60, board width in cells
- ROWS, 40, board height in cells
- CELL_LOG2, 3, log2 of cell size in pixels (8x8 cells)
- OBJ_SIZE, 32, object footprint in pixels (aliens and gold, square)
- N_ALIEN, 4, alien query channels (1..8)
- N_GOLD, 4, gold query channels (1..8)
- SOLID_RGB, 12'hA52, colour of solid terrain
- clk  in  1  system clock
- resetN  in  1  reset; one clock, reset synchronous active-low
- pixelX  in  11  current pixel X
- pixelY  in  11  current pixel Y
- player_inside  in  1  player collides with the current pixel
- alien_tlX  in  11*N_ALIEN  alien top-left X, channel i at [11i+10:11i]
- alien_tlY  in  11*N_ALIEN  alien top-left Y, same packing
- gold_tlX  in  11*N_GOLD  gold top-left X
- gold_tlY  in  11*N_GOLD  gold top-left Y
- free_dir  out  4*N_ALIEN  per alien {up,down,left,right} at [4i+3:4i]; 1 = free
- gold_can_fall  out  N_GOLD  per gold; 1 = cell below is dug
- scan_done  out  1  one-cycle pulse when free_dir/gold_can_fall update
- terrainDR  out  1  terrain drawing request
- terrainRGB  out  12  terrain colour
- dug_count  out  12  number of dug cells (see Configuration)

## Operation
- Map: COLS*ROWS register bits, 1 = solid. Reset: row 0 dug (surface), all other cells solid.
- Cell of a point (x,y): col = (x-BOARD_X)>>CELL_LOG2, row = (y-BOARD_Y)>>CELL_LOG2. A point outside the board is treated as solid.
- Draw: when the pixel is on the board and its cell is solid, terrainDR=1 and terrainRGB=SOLID_RGB. Otherwise terrainDR=0 and terrainRGB=0.
- Dig: when player_inside=1, the pixel is on the board and its cell is solid, the cell is cleared.
- Scan FSM: IDLE -> ALIEN -> GOLD -> DONE -> IDLE.
  - IDLE leaves on frame start (pixelX==0 && pixelY==0).
  - ALIEN performs 4 lookups per channel, in order right, left, down, up. Probe points: right (x+OBJ_SIZE,y); left (x-1,y); down (x,y+OBJ_SIZE); up (x,y-1). Each direction is free iff its probe cell is on the board and dug.
  - GOLD performs 1 lookup per channel at (x,y+OBJ_SIZE).
  - Results accumulate in shadow registers. In DONE they copy atomically to the outputs and scan_done pulses.
- A frame start during a scan is ignored. The next scan begins at the following frame start.
- Coordinates are sampled at each channel's lookup cycle, not latched at frame start.

## Timing
- Draw path: terrainDR and terrainRGB are registered, with 1-cycle latency from pixelX/pixelY.
- Dig: the cell clears on the clock edge after the qualifying pixel cycle.
- Dig vs lookup collision: a lookup of a cell in the same cycle it is cleared returns solid (old value). The draw path follows the same rule.
- Scan length: 4*N_ALIEN + N_GOLD lookup cycles, plus 1 DONE cycle. With the defaults, scan_done fires 21 cycles after the frame-start cycle.
- Reset values: free_dir=0, gold_can_fall=0, scan_done=0, terrainDR=0, terrainRGB=0, dug_count=COLS (row 0), FSM=IDLE.
- Reset during a scan discards the shadow results and restores the map to its reset state.

## Configuration
- TERRAIN_DIG_COUNT_EN defined: dug_count increments by 1 on each solid-to-dug transition and saturates at COLS*ROWS.
- Not defined: dug_count is tied to 0 and the counter logic is absent.

## Test plan
- Reset, then draw pixel (32,160) and pixel (32,168) -> 1 cycle later terrainDR=0 and then terrainDR=1, RGB=12'hA52.
- player_inside=1 at pixel (40,168) -> cell (1,1) clears. Next frame that pixel gives terrainDR=0; dug_count=61 with TERRAIN_DIG_COUNT_EN, 0 without.
- Alien 0 at (32,160), cell (4,0) dug and others solid, frame start -> scan_done 21 cycles later, free_dir[3:0]=4'b0001 (right only; up is off-board).
- Gold 2 at (64,160) with cell (4,4) dug -> gold_can_fall[2]=1. Repeat with cell (4,4) solid -> 0.
- Dig cell (4,4) in the exact cycle gold 2's lookup reads it -> gold_can_fall[2]=0 this scan, 1 on the next scan.
- resetN=0 mid-scan at cycle 10 -> all outputs 0 next cycle, no scan_done, map restored.

Source files
------------

// File: rtl/terrain_grid_multi.sv
// Cell-granular Digger terrain map: draws solid cells, clears dug cells, and scans
// per-frame alien/gold neighbourhoods. Optional dug-cell counter: TERRAIN_DIG_COUNT_EN.
module terrain_grid_multi #(
  parameter logic [10:0] BOARD_X   = 11'd32,
  parameter logic [10:0] BOARD_Y   = 11'd160,
  parameter int unsigned COLS      = 60,
  parameter int unsigned ROWS      = 40,
  parameter int unsigned CELL_LOG2 = 3,
  parameter int unsigned OBJ_SIZE  = 32,
  parameter int unsigned N_ALIEN   = 4,
  parameter int unsigned N_GOLD    = 4,
  parameter logic [11:0] SOLID_RGB = 12'hA52
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic [10:0]            pixelX,
  input  logic [10:0]            pixelY,
  input  logic                   player_inside,
  input  logic [11*N_ALIEN-1:0]  alien_tlX,
  input  logic [11*N_ALIEN-1:0]  alien_tlY,
  input  logic [11*N_GOLD-1:0]   gold_tlX,
  input  logic [11*N_GOLD-1:0]   gold_tlY,
  output logic [4*N_ALIEN-1:0]   free_dir,
  output logic [N_GOLD-1:0]      gold_can_fall,
  output logic                   scan_done,
  output logic                   terrainDR,
  output logic [11:0]            terrainRGB,
  output logic [11:0]            dug_count
);

  localparam int unsigned CELLS = COLS * ROWS;
  localparam int unsigned IDX_W = $clog2(CELLS);
  localparam int unsigned CW    = 12;
  localparam logic [CW-1:0] X_LO = CW'(BOARD_X);
  localparam logic [CW-1:0] Y_LO = CW'(BOARD_Y);
  localparam logic [CW-1:0] X_HI = CW'(BOARD_X) + CW'(COLS << CELL_LOG2);
  localparam logic [CW-1:0] Y_HI = CW'(BOARD_Y) + CW'(ROWS << CELL_LOG2);
  localparam logic [CELLS-1:0] MAP_RST = {{(CELLS-COLS){1'b1}}, {COLS{1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_ALIEN, S_GOLD, S_DONE} state_t;

  function automatic logic on_board(input logic [CW-1:0] x, input logic [CW-1:0] y);
    return (x >= X_LO) && (x < X_HI) && (y >= Y_LO) && (y < Y_HI);
  endfunction

  function automatic logic [IDX_W-1:0] cell_idx(input logic [CW-1:0] x, input logic [CW-1:0] y);
    logic [CW-1:0] col, row;
    col = (x - X_LO) >> CELL_LOG2;
    row = (y - Y_LO) >> CELL_LOG2;
    return IDX_W'(row * CW'(COLS) + col);
  endfunction

  logic [CELLS-1:0]   map_q;
  logic [CW-1:0]      pix_x, pix_y;
  logic [IDX_W-1:0]   pix_idx;
  logic               pix_solid_c, dig_c;
  logic               dr_q;
  logic [11:0]        rgb_q;

  state_t             state_q, state_d;
  logic [2:0]         ch_q, ch_d;
  logic [1:0]         dir_q, dir_d;
  logic [4*N_ALIEN-1:0] free_sh_q, free_sh_d, free_q, free_d;
  logic [N_GOLD-1:0]  gold_sh_q, gold_sh_d, gold_q, gold_d;
  logic               done_q, done_d;
  logic [CW-1:0]      probe_x, probe_y, cx, cy;
  logic               probe_free_c;
  logic [10:0]        ax [8];
  logic [10:0]        ay [8];
  logic [10:0]        gx [8];
  logic [10:0]        gy [8];

  // Unpack channel coordinates into fixed 8-entry tables indexed by ch_q
  for (genvar i = 0; i < 8; i++) begin : g_ch
    if (i < N_ALIEN) begin : g_a
      assign ax[i] = alien_tlX[11*i +: 11];
      assign ay[i] = alien_tlY[11*i +: 11];
    end else begin : g_az
      assign ax[i] = '0;
      assign ay[i] = '0;
    end
    if (i < N_GOLD) begin : g_g
      assign gx[i] = gold_tlX[11*i +: 11];
      assign gy[i] = gold_tlY[11*i +: 11];
    end else begin : g_gz
      assign gx[i] = '0;
      assign gy[i] = '0;
    end
  end

  assign pix_x = {1'b0, pixelX};
  assign pix_y = {1'b0, pixelY};

  always_comb begin
    pix_idx     = cell_idx(pix_x, pix_y);
    pix_solid_c = on_board(pix_x, pix_y) && map_q[pix_idx];
    dig_c       = player_inside && pix_solid_c;
  end

  // Map and draw path both see the pre-dig map value in the digging cycle
  always_ff @(posedge clk) begin
    if (!resetN) begin
      map_q <= MAP_RST;
      dr_q  <= 1'b0;
      rgb_q <= '0;
    end else begin
      if (dig_c) map_q[pix_idx] <= 1'b0;
      dr_q  <= pix_solid_c;
      rgb_q <= pix_solid_c ? SOLID_RGB : 12'h000;
    end
  end

  // Probe point for the current lookup; 12-bit math keeps x-1 at 0 off the board
  always_comb begin
    cx      = {1'b0, ax[ch_q]};
    cy      = {1'b0, ay[ch_q]};
    probe_x = cx;
    probe_y = cy;
    if (state_q == S_GOLD) begin
      probe_x = {1'b0, gx[ch_q]};
      probe_y = {1'b0, gy[ch_q]} + CW'(OBJ_SIZE);
    end else begin
      case (dir_q)
        2'd0:    probe_x = cx + CW'(OBJ_SIZE);
        2'd1:    probe_x = cx - CW'(1);
        2'd2:    probe_y = cy + CW'(OBJ_SIZE);
        default: probe_y = cy - CW'(1);
      endcase
    end
    probe_free_c = on_board(probe_x, probe_y) && !map_q[cell_idx(probe_x, probe_y)];
  end

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    dir_d     = dir_q;
    free_sh_d = free_sh_q;
    gold_sh_d = gold_sh_q;
    free_d    = free_q;
    gold_d    = gold_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pixelX == 11'd0 && pixelY == 11'd0) begin
          state_d = S_ALIEN;
          ch_d    = 3'd0;
          dir_d   = 2'd0;
        end
      end
      S_ALIEN: begin
        for (int i = 0; i < N_ALIEN; i++)
          for (int d = 0; d < 4; d++)
            if (ch_q == 3'(i) && dir_q == 2'(d)) free_sh_d[4*i+d] = probe_free_c;
        dir_d = dir_q + 2'd1;
        if (dir_q == 2'd3) begin
          if (ch_q == 3'(N_ALIEN-1)) begin
            ch_d    = 3'd0;
            state_d = S_GOLD;
          end else begin
            ch_d = ch_q + 3'd1;
          end
        end
      end
      S_GOLD: begin
        for (int i = 0; i < N_GOLD; i++)
          if (ch_q == 3'(i)) gold_sh_d[i] = probe_free_c;
        if (ch_q == 3'(N_GOLD-1)) begin
          ch_d    = 3'd0;
          state_d = S_DONE;
        end else begin
          ch_d = ch_q + 3'd1;
        end
      end
      S_DONE: begin
        free_d  = free_sh_q;
        gold_d  = gold_sh_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q   <= S_IDLE;
      ch_q      <= '0;
      dir_q     <= '0;
      free_sh_q <= '0;
      gold_sh_q <= '0;
      free_q    <= '0;
      gold_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      dir_q     <= dir_d;
      free_sh_q <= free_sh_d;
      gold_sh_q <= gold_sh_d;
      free_q    <= free_d;
      gold_q    <= gold_d;
      done_q    <= done_d;
    end
  end

`ifdef TERRAIN_DIG_COUNT_EN
  logic [11:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (dig_c && cnt_q != 12'(CELLS)) cnt_d = cnt_q + 12'd1;
  end

  always_ff @(posedge clk) begin
    if (!resetN) cnt_q <= 12'(COLS);
    else         cnt_q <= cnt_d;
  end

  assign dug_count = cnt_q;
`else
  assign dug_count = '0;
`endif

  assign free_dir      = free_q;
  assign gold_can_fall = gold_q;
  assign scan_done     = done_q;
  assign terrainDR     = dr_q;
  assign terrainRGB    = rgb_q;

endmodule

// File: tb/tb_terrain_grid_multi.sv
// Bench for terrain_grid_multi: directed scenarios plus random traffic against a
// cell-array reference model of map, draw, dig and the per-frame neighbourhood scan.
module tb_terrain_grid_multi;
  localparam int NA = 4, NG = 4, COLS = 60, ROWS = 40;
  localparam int BX = 32, BY = 160, OBJ = 32, CL = 3;
  localparam int NLOOK = 4*NA + NG;

  logic               clk = 1'b0;
  logic               resetN = 1'b0;
  logic [10:0]        pixelX = 11'd600, pixelY = 11'd600;
  logic               player_inside = 1'b0;
  logic [11*NA-1:0]   alien_tlX = '0, alien_tlY = '0;
  logic [11*NG-1:0]   gold_tlX = '0, gold_tlY = '0;
  logic [4*NA-1:0]    free_dir;
  logic [NG-1:0]      gold_can_fall;
  logic               scan_done, terrainDR;
  logic [11:0]        terrainRGB, dug_count;

  terrain_grid_multi dut (
    .clk(clk), .resetN(resetN), .pixelX(pixelX), .pixelY(pixelY),
    .player_inside(player_inside),
    .alien_tlX(alien_tlX), .alien_tlY(alien_tlY),
    .gold_tlX(gold_tlX), .gold_tlY(gold_tlY),
    .free_dir(free_dir), .gold_can_fall(gold_can_fall), .scan_done(scan_done),
    .terrainDR(terrainDR), .terrainRGB(terrainRGB), .dug_count(dug_count)
  );

  always #5 clk = ~clk;

  bit           mdl_map [ROWS][COLS];
  int           scan_pos;
  logic [4*NA-1:0] sh_free, exp_free;
  logic [NG-1:0]   sh_gold, exp_gold;
  logic         exp_done, exp_dr;
  logic [11:0]  exp_rgb, exp_cnt;
  int           total = 0, bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit on_brd(int x, int y);
    return x >= BX && x < BX + (COLS << CL) && y >= BY && y < BY + (ROWS << CL);
  endfunction

  function automatic bit solid_at(int x, int y);
    if (!on_brd(x, y)) return 1'b1;
    return mdl_map[(y - BY) >> CL][(x - BX) >> CL];
  endfunction

  task automatic model_reset();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) mdl_map[r][c] = (r != 0);
    scan_pos = -1;
    sh_free = '0; sh_gold = '0; exp_free = '0; exp_gold = '0;
    exp_done = 1'b0; exp_dr = 1'b0; exp_rgb = '0;
`ifdef TERRAIN_DIG_COUNT_EN
    exp_cnt = 12'(COLS);
`else
    exp_cnt = '0;
`endif
  endtask

  // Predict effects of the coming clock edge from current inputs, advance, then compare
  task automatic step();
    int px, py, x, y, ch, d;
    bit sol;
    if (!resetN) begin
      @(posedge clk); #1;
      model_reset();
    end else begin
      px = int'(pixelX); py = int'(pixelY);
      sol = on_brd(px, py) && solid_at(px, py);
      exp_dr = sol;
      exp_rgb = sol ? 12'hA52 : 12'h000;
      exp_done = 1'b0;
      if (scan_pos < 0) begin
        if (px == 0 && py == 0) scan_pos = 0;
      end else if (scan_pos < 4*NA) begin
        ch = scan_pos / 4; d = scan_pos % 4;
        x = int'(alien_tlX[11*ch +: 11]); y = int'(alien_tlY[11*ch +: 11]);
        case (d)
          0:       sh_free[4*ch+d] = !solid_at(x + OBJ, y);
          1:       sh_free[4*ch+d] = !solid_at(x - 1, y);
          2:       sh_free[4*ch+d] = !solid_at(x, y + OBJ);
          default: sh_free[4*ch+d] = !solid_at(x, y - 1);
        endcase
        scan_pos++;
      end else if (scan_pos < NLOOK) begin
        ch = scan_pos - 4*NA;
        x = int'(gold_tlX[11*ch +: 11]); y = int'(gold_tlY[11*ch +: 11]);
        sh_gold[ch] = !solid_at(x, y + OBJ);
        scan_pos++;
      end else begin
        exp_free = sh_free; exp_gold = sh_gold; exp_done = 1'b1;
        scan_pos = -1;
      end
      if (player_inside && sol) begin
        mdl_map[(py - BY) >> CL][(px - BX) >> CL] = 1'b0;
`ifdef TERRAIN_DIG_COUNT_EN
        if (exp_cnt < 12'(COLS*ROWS)) exp_cnt = exp_cnt + 12'd1;
`endif
      end
      @(posedge clk); #1;
    end
    check("terrainDR", 32'(terrainDR), 32'(exp_dr));
    check("terrainRGB", 32'(terrainRGB), 32'(exp_rgb));
    check("scan_done", 32'(scan_done), 32'(exp_done));
    check("free_dir", 32'(free_dir), 32'(exp_free));
    check("gold_can_fall", 32'(gold_can_fall), 32'(exp_gold));
    check("dug_count", 32'(dug_count), 32'(exp_cnt));
  endtask

  task automatic set_pix(input int x, input int y, input bit pi);
    pixelX = 11'(x); pixelY = 11'(y); player_inside = pi;
  endtask

  task automatic frame_scan(input int dig_k);
    set_pix(0, 0, 1'b0);
    step();
    for (int k = 1; k <= NLOOK + 1; k++) begin
      if (k == dig_k) set_pix(64, 192, 1'b1);
      else set_pix(600, 600, 1'b0);
      step();
      if (k <= NLOOK) check("scan_early", 32'(scan_done), 32'd0);
    end
    set_pix(600, 600, 1'b0);
    check("scan_done_21", 32'(scan_done), 32'd1);
  endtask

  initial begin
    model_reset();
    for (int i = 0; i < NA; i++) begin
      alien_tlX[11*i +: 11] = 11'd200; alien_tlY[11*i +: 11] = 11'd300;
    end
    for (int i = 0; i < NG; i++) begin
      gold_tlX[11*i +: 11] = 11'd300; gold_tlY[11*i +: 11] = 11'd400;
    end
    alien_tlX[10:0] = 11'd32; alien_tlY[10:0] = 11'd160;
    gold_tlX[32:22] = 11'd64; gold_tlY[32:22] = 11'd160;

    step(); step();
`ifdef TERRAIN_DIG_COUNT_EN
    check("rst_dug_count", 32'(dug_count), 32'd60);
`else
    check("rst_dug_count", 32'(dug_count), 32'd0);
`endif
    check("rst_scan_done", 32'(scan_done), 32'd0);
    resetN = 1'b1;

    set_pix(32, 160, 1'b0); step();
    check("draw_surface", 32'(terrainDR), 32'd0);
    set_pix(32, 168, 1'b0); step();
    check("draw_solid", 32'(terrainDR), 32'd1);
    check("draw_rgb", 32'(terrainRGB), 32'hA52);

    set_pix(40, 168, 1'b1); step();
    set_pix(40, 168, 1'b0); step();
    check("dug_cell_draw", 32'(terrainDR), 32'd0);
`ifdef TERRAIN_DIG_COUNT_EN
    check("dug_count_61", 32'(dug_count), 32'd61);
`else
    check("dug_count_off", 32'(dug_count), 32'd0);
`endif

    set_pix(64, 192, 1'b1); step();
    frame_scan(0);
    check("alien0_free", 32'(free_dir[3:0]), 32'h1);
    check("gold2_fall", 32'(gold_can_fall[2]), 32'd1);

    resetN = 1'b0; step(); resetN = 1'b1;
    frame_scan(0);
    check("gold2_solid", 32'(gold_can_fall[2]), 32'd0);

    frame_scan(19);
    check("gold2_collide", 32'(gold_can_fall[2]), 32'd0);
    frame_scan(0);
    check("gold2_after", 32'(gold_can_fall[2]), 32'd1);

    set_pix(0, 0, 1'b0); step();
    set_pix(600, 600, 1'b0);
    for (int k = 1; k < 10; k++) step();
    resetN = 1'b0; step(); resetN = 1'b1;
    check("rst_mid_dr", 32'(terrainDR), 32'd0);
    check("rst_mid_free", 32'(free_dir), 32'd0);
    check("rst_mid_gold", 32'(gold_can_fall), 32'd0);
    for (int k = 0; k < 25; k++) begin
      step();
      check("no_done_after_rst", 32'(scan_done), 32'd0);
    end
    set_pix(40, 168, 1'b0); step();
    check("map_restored_a", 32'(terrainDR), 32'd1);
    set_pix(64, 192, 1'b0); step();
    check("map_restored_b", 32'(terrainDR), 32'd1);

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 39) == 0) set_pix(0, 0, 1'b0);
      else if ($urandom_range(0, 9) == 0)
        set_pix(int'($urandom_range(0, 700)), int'($urandom_range(0, 700)), 1'b0);
      else
        set_pix(BX + int'($urandom_range(0, 79)), BY + int'($urandom_range(0, 79)), 1'b0);
      player_inside = ($urandom_range(0, 2) == 0);
      for (int i = 0; i < NA; i++)
        if ($urandom_range(0, 3) == 0) begin
          alien_tlX[11*i +: 11] = 11'($urandom_range(0, 120));
          alien_tlY[11*i +: 11] = 11'($urandom_range(130, 260));
        end
      for (int i = 0; i < NG; i++)
        if ($urandom_range(0, 3) == 0) begin
          gold_tlX[11*i +: 11] = 11'($urandom_range(0, 120));
          gold_tlY[11*i +: 11] = 11'($urandom_range(130, 260));
        end
      resetN = ($urandom_range(0, 999) != 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
